// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage store buffer.
// Byte coverage is computed with 16-bit modulo arithmetic, so A+1 wraps from 0xFFFF to 0x0000.
package mem_pkg;

    localparam int WORD_BYTES   = 2;
    localparam int LOW_BYTE_OFS = 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        is_byte;
    } sb_entry_t;

    // A word entry covers {a, a+1}; a byte entry covers only a+1.
    function automatic logic entry_covers(input sb_entry_t e, input logic [15:0] b);
        logic [15:0] ofs;
        ofs = b - e.addr;
        if (e.is_byte) return ofs == 16'(LOW_BYTE_OFS);
        return ofs < 16'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_store_buffer_stage_if.sv
// EX/MEM inputs, data-memory port and MEM/WB outputs of the store-buffer stage.
// The slave modport is the stage itself; master is the surrounding pipeline plus memory.
interface mem_store_buffer_stage_if #(parameter int RW = 4);

    logic          ex_valid;
    logic          ex_memRead;
    logic          ex_memWrite;
    logic          ex_storeByte;
    logic [15:0]   ex_addr;
    logic [15:0]   ex_wdata;
    logic          ex_regWrite;
    logic [RW-1:0] ex_rd;
    logic          stall_out;

    logic [15:0]   dm_Address;
    logic [15:0]   dm_WriteData;
    logic [7:0]    dm_WriteByte;
    logic          dm_memWrite;
    logic          dm_StoreOffset;
    logic [15:0]   dm_ReadData;

    logic          wb_valid;
    logic          wb_regWrite;
    logic [RW-1:0] wb_rd;
    logic [15:0]   wb_data;
    logic          buf_empty;

    modport slave (
        input  ex_valid, ex_memRead, ex_memWrite, ex_storeByte, ex_addr, ex_wdata,
               ex_regWrite, ex_rd, dm_ReadData,
        output stall_out, dm_Address, dm_WriteData, dm_WriteByte, dm_memWrite,
               dm_StoreOffset, wb_valid, wb_regWrite, wb_rd, wb_data, buf_empty
    );

    modport master (
        output ex_valid, ex_memRead, ex_memWrite, ex_storeByte, ex_addr, ex_wdata,
               ex_regWrite, ex_rd, dm_ReadData,
        input  stall_out, dm_Address, dm_WriteData, dm_WriteByte, dm_memWrite,
               dm_StoreOffset, wb_valid, wb_regWrite, wb_rd, wb_data, buf_empty
    );

endinterface

// File: rtl/sb_fifo.sv
// In-order circular store buffer. Besides the head, every slot is exposed in age order
// (index 0 = oldest) so the load-forwarding logic can search all pending stores in parallel.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  sb_entry_t                    push_entry,
    output sb_entry_t                    head,
    output sb_entry_t                    age_entries [DEPTH],
    output logic [DEPTH-1:0]             age_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    sb_entry_t     slots [DEPTH];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] age_index(input logic [PW-1:0] base, input int ofs);
        int k;
        k = int'(base) + ofs;
        if (k >= DEPTH) k = k - DEPTH;
        return PW'(k);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: slot storage is deliberately not reset; count/pointers alone decide validity,
    // which keeps the array a plain register file without a reset network.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_entry;
    end

    assign head = slots[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = slots[age_index(rd_ptr, i)];
            age_valid[i]   = (i < int'(count));
        end
    end

endmodule

// File: rtl/mem_store_buffer_stage.sv
// MEM stage: stores are buffered and drained when the memory port is free; loads read memory
// combinationally, forward from buffered stores, or stall on a partial overlap.
module mem_store_buffer_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_store_buffer_stage_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            is_load;
    logic            is_store;
    logic            load_ok;
    logic            drain;
    logic            stall;
    logic [15:0]     addr_lo;
    sb_entry_t       push_entry;
    sb_entry_t       head;
    sb_entry_t       young;
    sb_entry_t       age_e [DEPTH];
    logic [DEPTH-1:0] age_v;
    logic [CW-1:0]   count;
    logic            overlap;
    logic            hit_hi;
    logic            fwd_word;
    logic            fwd_byte;
    logic [15:0]     load_data;

    logic            wb_valid_q;
    logic            wb_regw_q;
    logic [RW-1:0]   wb_rd_q;
    logic [15:0]     wb_data_q;

    assign is_load    = bus.ex_valid & bus.ex_memRead & ~bus.ex_memWrite;
    assign is_store   = bus.ex_valid & bus.ex_memWrite;
    assign addr_lo    = bus.ex_addr + 16'(LOW_BYTE_OFS);
    assign push_entry = '{addr: bus.ex_addr, data: bus.ex_wdata, is_byte: bus.ex_storeByte};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (is_store),
        .pop        (drain),
        .push_entry (push_entry),
        .head       (head),
        .age_entries(age_e),
        .age_valid  (age_v),
        .count      (count)
    );

    // Walk oldest to youngest so the last overlapping entry seen is the youngest one.
    always_comb begin
        overlap = 1'b0;
        hit_hi  = 1'b0;
        young   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_v[i] && entry_covers(age_e[i], bus.ex_addr)) hit_hi = 1'b1;
            if (age_v[i] && (entry_covers(age_e[i], bus.ex_addr) ||
                             entry_covers(age_e[i], addr_lo))) begin
                overlap = 1'b1;
                young   = age_e[i];
            end
        end
    end

    // A byte entry at A supplies only the low byte, so it may forward only if nothing
    // pending touches the high byte.
    assign fwd_word = overlap & ~young.is_byte & (young.addr == bus.ex_addr);
    assign fwd_byte = overlap &  young.is_byte & (young.addr == bus.ex_addr) & ~hit_hi;
    assign stall    = is_load & overlap & ~(fwd_word | fwd_byte);
    assign load_ok  = is_load & ~stall;
    assign drain    = ~load_ok & (count != '0);

    always_comb begin
        load_data = bus.dm_ReadData;
        if (fwd_word)      load_data = young.data;
        else if (fwd_byte) load_data = {bus.dm_ReadData[15:8], young.data[7:0]};
    end

    // The write strobe is masked during reset: entries being discarded must never reach memory.
    always_comb begin
        bus.dm_Address     = bus.ex_addr;
        bus.dm_memWrite    = 1'b0;
        bus.dm_WriteData   = '0;
        bus.dm_WriteByte   = '0;
        bus.dm_StoreOffset = 1'b0;
        if (drain) begin
            bus.dm_Address     = head.addr;
            bus.dm_memWrite    = rst;
            bus.dm_WriteData   = head.data;
            bus.dm_WriteByte   = head.data[7:0];
            bus.dm_StoreOffset = head.is_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= bus.ex_valid & ~stall;
            wb_regw_q  <= bus.ex_valid & ~stall & ~is_store & bus.ex_regWrite;
            if (bus.ex_valid && !stall) begin
                wb_rd_q   <= bus.ex_rd;
                wb_data_q <= is_load ? load_data : bus.ex_addr;
            end
        end
    end

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_regWrite = wb_regw_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.stall_out   = stall;
    assign bus.buf_empty   = (count == '0);

endmodule

// File: tb/tb_mem_store_buffer_stage.sv
// Scoreboard bench: program-order memory model predicts MEM/WB results; a byte-array memory
// answers the DUT port, and is compared with the model once all stores have drained.
module tb_mem_store_buffer_stage;

    typedef struct {
        int          cyc;
        logic        rw;
        logic [3:0]  rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    logic [7:0]  tb_mem  [65536];
    logic [7:0]  ref_mem [65536];
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [15:0] wr_log [$];
    logic [15:0] dm_a1;

    mem_store_buffer_stage_if #(.RW(4)) bus ();

    mem_store_buffer_stage #(.DEPTH(2), .RW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dm_a1 = bus.dm_Address + 16'd1;
    assign bus.dm_ReadData = {tb_mem[bus.dm_Address], tb_mem[dm_a1]};

    always @(posedge clk) begin
        if (bus.dm_memWrite) begin
            wr_log.push_back(bus.dm_Address);
            if (bus.dm_StoreOffset) tb_mem[dm_a1] <= bus.dm_WriteByte;
            else begin
                tb_mem[bus.dm_Address] <= bus.dm_WriteData[15:8];
                tb_mem[dm_a1]          <= bus.dm_WriteData[7:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wb_valid) begin
            if (exp_q.size() == 0) check("wb_unexpected", 32'(bus.wb_valid), 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("wb_data", 32'(bus.wb_data), 32'(mon_e.data));
                check("wb_regWrite", 32'(bus.wb_regWrite), 32'(mon_e.rw));
                check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            check("wb_missing", 32'(bus.wb_valid), 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic drive_idle();
        bus.ex_valid     = 1'b0;
        bus.ex_memRead   = 1'b0;
        bus.ex_memWrite  = 1'b0;
        bus.ex_storeByte = 1'b0;
        bus.ex_addr      = 16'h0000;
        bus.ex_wdata     = 16'h0000;
        bus.ex_regWrite  = 1'b0;
        bus.ex_rd        = 4'd0;
    endtask

    // Presents one instruction, holds it while stalled, records the expected MEM/WB result
    // from the architectural memory model at the cycle it is accepted.
    task automatic issue(input logic v, input logic rd_op, input logic wr_op, input logic bt,
                         input logic [15:0] a, input logic [15:0] d, input logic rw,
                         input logic [3:0] rd, output int stalls, output logic mw);
        exp_t        e;
        logic        ld;
        logic [15:0] a1;
        stalls = 0;
        mw     = 1'b0;
        ld     = v & rd_op & ~wr_op;
        a1     = a + 16'd1;
        bus.ex_valid     = v;
        bus.ex_memRead   = rd_op;
        bus.ex_memWrite  = wr_op;
        bus.ex_storeByte = bt;
        bus.ex_addr      = a;
        bus.ex_wdata     = d;
        bus.ex_regWrite  = rw;
        bus.ex_rd        = rd;
        @(negedge clk);
        while (bus.stall_out && stalls <= 16) begin
            check("stall_only_loads", 32'(ld), 32'd1);
            stalls++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        if (bus.stall_out) begin
            check("stall_timeout", 32'(bus.stall_out), 32'd0);
            drive_idle();
            @(posedge clk);
            #1;
            return;
        end
        mw = bus.dm_memWrite;
        if (v) begin
            e.cyc  = cyc + 1;
            e.rw   = rw & ~wr_op;
            e.rd   = rd;
            e.data = ld ? {ref_mem[a], ref_mem[a1]} : a;
            if (wr_op) begin
                if (!bt) ref_mem[a] = d[15:8];
                ref_mem[a1] = d[7:0];
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive_idle();
            @(negedge clk);
            done = bus.buf_empty;
            @(posedge clk);
            #1;
        end
        if (!done) check("drain_timeout", 32'(bus.buf_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        logic        mw;
        logic [7:0]  old40;
        logic [7:0]  old41;
        int          op;
        logic [15:0] ra;
        logic [15:0] rdat;

        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        tb_mem[0]  = 8'h3C; tb_mem[1]  = 8'hAD;
        ref_mem[0] = 8'h3C; ref_mem[1] = 8'hAD;

        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_regWrite", 32'(bus.wb_regWrite), 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("rst_wb_data", 32'(bus.wb_data), 32'd0);
        check("rst_buf_empty", 32'(bus.buf_empty), 32'd1);
        check("rst_stall", 32'(bus.stall_out), 32'd0);
        check("rst_memWrite", 32'(bus.dm_memWrite), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Store then free port: drain appears the next cycle.
        issue(1, 0, 1, 0, 16'h0010, 16'h1234, 1, 4'd1, st, mw);
        check("t1_store_nostall", 32'(st), 32'd0);
        drive_idle();
        @(negedge clk);
        check("t1_memWrite", 32'(bus.dm_memWrite), 32'd1);
        check("t1_addr", 32'(bus.dm_Address), 32'h0010);
        check("t1_wdata", 32'(bus.dm_WriteData), 32'h1234);
        check("t1_offset", 32'(bus.dm_StoreOffset), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_empty_after", 32'(bus.buf_empty), 32'd1);
        @(posedge clk);
        #1;

        // Exact word forward; load owns the port, drain follows.
        issue(1, 0, 1, 0, 16'h0020, 16'hBEEF, 0, 4'd0, st, mw);
        issue(1, 1, 0, 0, 16'h0020, 16'h0000, 1, 4'd2, st, mw);
        check("t2_load_nostall", 32'(st), 32'd0);
        check("t2_no_write_on_load", 32'(mw), 32'd0);
        drive_idle();
        @(negedge clk);
        check("t2_drain_write", 32'(bus.dm_memWrite), 32'd1);
        check("t2_drain_addr", 32'(bus.dm_Address), 32'h0020);
        @(posedge clk);
        #1;
        wait_empty();

        // Byte store merge with memory high byte.
        issue(1, 0, 1, 1, 16'h0000, 16'h5577, 0, 4'd0, st, mw);
        issue(1, 1, 0, 0, 16'h0000, 16'h0000, 1, 4'd3, st, mw);
        check("t3_load_nostall", 32'(st), 32'd0);
        wait_empty();
        check("t3_mem1", 32'(tb_mem[1]), 32'h77);
        check("t3_mem0", 32'(tb_mem[0]), 32'h3C);

        // Partial overlap forces a stall until the buffer drains.
        issue(1, 0, 1, 0, 16'h0005, 16'hCAFE, 0, 4'd0, st, mw);
        issue(1, 1, 0, 0, 16'h0004, 16'h0000, 1, 4'd4, st, mw);
        check("t4_stall_cycles", 32'(st), 32'd1);
        wait_empty();

        // Back-to-back stores never stall and drain in order.
        wr_log.delete();
        issue(1, 0, 1, 0, 16'h0030, 16'h1111, 0, 4'd0, st, mw);
        check("t5_st0", 32'(st), 32'd0);
        issue(1, 0, 1, 0, 16'h0032, 16'h2222, 0, 4'd0, st, mw);
        check("t5_st1", 32'(st), 32'd0);
        issue(1, 0, 1, 0, 16'h0034, 16'h3333, 0, 4'd0, st, mw);
        check("t5_st2", 32'(st), 32'd0);
        wait_empty();
        check("t5_nwrites", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_log.size(); i++)
            check("t5_order", 32'(wr_log[i]), 32'h0030 + 32'(2 * i));

        // Reset with a pending store: it is discarded and never written.
        old40 = ref_mem[16'h0040];
        old41 = ref_mem[16'h0041];
        issue(1, 0, 1, 0, 16'h0040, 16'hA5A5, 0, 4'd0, st, mw);
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        check("t6_no_write_in_reset", 32'(bus.dm_memWrite), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ref_mem[16'h0040] = old40;
        ref_mem[16'h0041] = old41;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_empty", 32'(bus.buf_empty), 32'd1);
            check("t6_no_write", 32'(bus.dm_memWrite), 32'd0);
            check("t6_wb_valid", 32'(bus.wb_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Address wrap at 0xFFFF.
        issue(1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 4'd0, st, mw);
        issue(1, 1, 0, 0, 16'hFFFF, 16'h0000, 1, 4'd5, st, mw);
        check("t6_wrap_fwd_nostall", 32'(st), 32'd0);
        issue(1, 1, 0, 0, 16'h0000, 16'h0000, 1, 4'd6, st, mw);
        check("t6_wrap_overlap_stall", 32'(st), 32'd1);
        wait_empty();

        // Random mix over a small window to provoke overlaps.
        for (int n = 0; n < 400; n++) begin
            op   = int'($urandom_range(0, 9));
            ra   = 16'h0080 + 16'($urandom_range(0, 15));
            rdat = 16'($urandom);
            case (op)
                0:          issue(0, 0, 0, 0, ra, rdat, 1'($urandom), 4'($urandom), st, mw);
                1, 2:       issue(1, 0, 0, 0, ra, rdat, 1'($urandom), 4'($urandom), st, mw);
                3, 4, 5:    issue(1, 1, 0, 0, ra, rdat, 1'($urandom), 4'($urandom), st, mw);
                6, 7:       issue(1, 0, 1, 0, ra, rdat, 1'($urandom), 4'($urandom), st, mw);
                default:    issue(1, 0, 1, 1, ra, rdat, 1'($urandom), 4'($urandom), st, mw);
            endcase
        end
        wait_empty();
        repeat (2) begin
            drive_idle();
            @(posedge clk);
            #1;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 256; i++)
            check("mem_final", 32'(tb_mem[i]), 32'(ref_mem[i]));
        check("mem_final_ffff", 32'(tb_mem[65535]), 32'(ref_mem[65535]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
